// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//   Receiver for the single-wire serial link. The line is synchronised,
//   a start bit is detected and confirmed at mid-bit, DATA_W data bits are
//   sampled LSB-first at mid-bit, and the stop bit is checked. Good words
//   are presented on a valid/ready port backed by a one-entry holding buffer.
//
// Parameters
//   DATA_W        data bits per frame (1..16)
//   CLKS_PER_BIT  clock cycles per serial bit (even, >= 2)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   rx         serial line (idle 1, start 0, stop 1), asynchronous to clk
//   out_data   received word, meaningful while out_valid=1
//   out_valid  holding buffer full
//   out_ready  consumer accepts; transfer on out_valid & out_ready
//   frame_err  one-cycle pulse: stop bit sampled low
//   overrun    one-cycle pulse: good frame dropped because buffer stayed full
// -----------------------------------------------------------------------------
module serial_frame_rx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CYC_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q;
  logic                rx_s_q;
  logic [CW-1:0]       cyc_q, cyc_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

  // Sampling instants within each state.
  logic start_mid;
  logic data_tick;
  logic stop_tick;

  assign start_mid = (state_q == START) && (cyc_q == CYC_HALF);
  assign data_tick = (state_q == DATA)  && (cyc_q == CYC_LAST);
  assign stop_tick = (state_q == STOP)  && (cyc_q == CYC_LAST);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, regardless of order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      // Synchroniser resets to the idle line level so no false start is seen.
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      cyc_q       <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= rx;
      rx_s_q      <= sync1_q;
      cyc_q       <= cyc_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default on entry so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!rx_s_q) state_d = START;
      // A line that is high again at mid start bit was a glitch.
      START: if (start_mid) state_d = rx_s_q ? IDLE : DATA;
      DATA:  if (data_tick && (bit_q == BIT_LAST)) state_d = STOP;
      STOP:  if (stop_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath, holding buffer and flag outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    cyc_d       = (cyc_q == CYC_LAST) ? '0 : cyc_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    out_data_d  = out_data_q;
    // A completed handshake empties the buffer unless a load refills it below.
    out_valid_d = out_valid_q & ~out_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;

    // The cycle counter restarts on every state entry and is parked in IDLE.
    if ((state_d != state_q) || (state_q == IDLE)) begin
      cyc_d = '0;
    end

    if (start_mid && !rx_s_q) begin
      bit_d = '0;
    end

    if (data_tick) begin
      // Shift right with the new sample entering at the MSB: after DATA_W
      // samples the first bit received sits in bit 0.
      shift_d         = shift_q >> 1;
      shift_d[DATA_W-1] = rx_s_q;
      bit_d           = bit_q + BW'(1);
    end

    if (stop_tick) begin
      if (rx_s_q) begin
        if (!out_valid_q || out_ready) begin
          out_data_d  = shift_q;
          out_valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else begin
        frame_err_d = 1'b1;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Receiving end of the team's single-wire serial link. Our D flip-flop and shift-register blocks form the transmit path; this block is its receiver.
- Synchronises the serial line and detects a start bit, then samples DATA_W data bits LSB-first at mid-bit and checks the stop bit.
- Presents each received word on a valid/ready output port backed by a one-entry holding buffer.
- Sits between the pad-level serial input and the parallel consumer logic.

Parameters:
- DATA_W, 8, data bits per frame (1..16).
- CLKS_PER_BIT, 4, clock cycles per serial bit; even, >= 2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 resets immediately, independent of clk.
- rx  input  1  serial line. Idle high, start bit 0, stop bit 1. Asynchronous to clk.
- out_data  output  DATA_W  received word; valid only while out_valid=1.
- out_valid  output  1  holding buffer full.
- out_ready  input  1  consumer accepts; transfer occurs when out_valid & out_ready.
- frame_err  output  1  one-cycle pulse: stop bit sampled 0.
- overrun  output  1  one-cycle pulse: good frame completed while buffer full and not being drained.

Behaviour:
- Reset values (rst=0):
  - state=IDLE, bit counter=0, cycle counter=0, shift register=0.
  - Both synchroniser flops=1 (line idle).
  - out_data=0, out_valid=0, frame_err=0, overrun=0.
  - A reset mid-frame abandons the frame; no flags are raised.
- Synchroniser:
  - rx passes through two flip-flops; rx_s is the second stage.
  - All decisions use rx_s, so there is 2 cycles of input latency.
- Cycle counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - It is cleared on every state entry.
- IDLE:
  - rx_s=0 -> START, cycle counter=0.
- START:
  - At cycle count CLKS_PER_BIT/2-1, sample rx_s (mid start bit).
  - If rx_s=0 -> DATA, bit counter=0, cycle counter cleared.
  - If rx_s=1 -> IDLE (glitch rejected, no flag).
- DATA:
  - At each cycle count CLKS_PER_BIT-1 (one full bit later, i.e. mid-bit), sample rx_s.
  - Shift the sample into the MSB of the shift register and shift right, so the word is LSB-first.
  - Increment the bit counter; after DATA_W samples -> STOP.
- STOP:
  - At cycle count CLKS_PER_BIT-1, sample rx_s.
  - If rx_s=1, the frame is good: do the buffer load (below), then -> IDLE.
  - If rx_s=0: frame_err=1 for one cycle, word discarded, buffer untouched, -> IDLE.
  - IDLE re-arms immediately; a line still low re-enters START the next cycle.
- Holding buffer, on good-frame completion:
  - If out_valid=0, or out_valid=1 with out_ready=1 in the same cycle: out_data<=word and out_valid<=1.
  - Otherwise: overrun=1 for one cycle, new word dropped, old out_data and out_valid kept.
- Holding buffer, handshake:
  - out_valid falls the cycle after out_valid & out_ready, unless a simultaneous load occurs; then it stays 1 with the new data.
  - out_data is stable while out_valid=1 and not accepted.
  - out_ready is ignored while out_valid=0.
- Latency:
  - out_valid rises exactly 2 + CLKS_PER_BIT/2 + (DATA_W+1)*CLKS_PER_BIT cycles after the first clk edge seeing rx=0.
  - With defaults that is 40 cycles.
- Back-to-back frames: no idle gap is required beyond the stop bit.

Test Plan:
- Reset held low, rx toggling -> all outputs 0. Release rst -> out_valid stays 0 until a start bit arrives.
- Defaults, frame 0xA5 (LSB-first), out_ready=1 -> out_data=0xA5 and out_valid high 1 cycle, 40 cycles after start edge; frame_err=0.
- Frame 0x3C with stop bit forced 0 -> frame_err pulses 1 cycle; out_valid stays 0.
- 1-cycle low glitch on rx while idle -> START rejected; no output, no flags.
- out_ready=0, frames 0x11 then 0x22 back-to-back -> out_data=0x11 held, overrun pulses at end of 2nd frame. Raise out_ready -> 0x11 accepted, out_valid falls.
- rst asserted mid-DATA of frame 0x5A, then deasserted, then frame 0x0F sent -> only 0x0F is delivered, with no flags.
